// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    function automatic logic bcd_valid(input logic [3:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/seven_segment_display_decoder.sv
// BCD to common-cathode seven-segment decoder, segments ordered {g,f,e,d,c,b,a}.
// Codes above 9 produce a dark digit.
module seven_segment_display_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] binary_input,
    output logic [6:0] segment_output
);

    // Pure lookup; the caller registers the code and gates the result.
    always_comb begin
        segment_output = SEG_BLANK;
        case (binary_input)
            4'd0:    segment_output = 7'b0111111;
            4'd1:    segment_output = 7'b0000110;
            4'd2:    segment_output = 7'b1011011;
            4'd3:    segment_output = 7'b1001111;
            4'd4:    segment_output = 7'b1100110;
            4'd5:    segment_output = 7'b1101101;
            4'd6:    segment_output = 7'b1111101;
            4'd7:    segment_output = 7'b0000111;
            4'd8:    segment_output = 7'b1111111;
            4'd9:    segment_output = 7'b1101111;
            default: segment_output = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan controller for a common-cathode seven-segment display.
//
// state | meaning
// IDLE  | scanning off, outputs dark, displayed frame tracks pending frame
// SHOW  | active part of a digit slot, selected digit driven
// BLANK | tail of a digit slot, all digits dark (anti-ghosting gap)
//
// The slot timer counts down from SCAN_DIV-1 to 0; a count of SCAN_DIV-1
// is the first cycle of a slot. All outputs are registered from the
// next-state values so they line up with the state they describe.
module seven_segment_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              seg_out,
    output logic [3:0]              digit_code,
    output logic                    frame_done,
    output logic                    code_err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMR_W = $clog2(SCAN_DIV + 1);

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(SCAN_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_BLANK = TMR_W'(BLANK_CYCLES);

    logic [1:0]              rst_sync;
    logic                    rst_int_n;
    scan_state_e             state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [TMR_W-1:0]        tmr, tmr_nxt;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] pend, disp, disp_nxt;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    nz_above;
    logic [3:0]              code_nxt;
    logic                    show_nxt, supp_nxt, bad_nxt;
    logic                    blank_q;
    logic [6:0]              seg_raw;

    // Reset asserts immediately, releases two clock edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    // Pending frame: the most recent load always wins.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)  pend <= '0;
        else if (load)   pend <= digits_in;
    end

    // Scan state, slot index, slot timer and displayed frame.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= IDLE;
            idx   <= '0;
            tmr   <= TMR_LOAD;
            disp  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            tmr   <= tmr_nxt;
            disp  <= disp_nxt;
        end
    end

    // Next-state: slot sequencing, frame wrap and the disp transfer point.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmr_nxt   = tmr;
        wrap      = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            tmr_nxt   = TMR_LOAD;
        end else if (state == IDLE) begin
            state_nxt = SHOW;
            idx_nxt   = '0;
            tmr_nxt   = TMR_LOAD;
        end else if (tmr == '0) begin
            state_nxt = SHOW;
            tmr_nxt   = TMR_LOAD;
            if (idx == IDX_LAST) begin
                idx_nxt = '0;
                wrap    = 1'b1;
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end else begin
            tmr_nxt   = tmr - 1'b1;
            state_nxt = (tmr > TMR_BLANK) ? SHOW : BLANK;
        end
        // pend is read before this edge's load lands, so a load on the
        // wrap edge waits for the following wrap.
        disp_nxt = (state == IDLE || wrap) ? pend : disp;
    end

    // Leading-zero mask: a position is suppressible when it and every
    // position above it hold zero; position 0 always stays lit.
    always_comb begin
        lz_mask  = '0;
        nz_above = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            nz_above   = nz_above | (disp_nxt[4*i +: 4] != 4'd0);
            lz_mask[i] = ~nz_above;
        end
    end

    // Per-slot decode of what the next cycle must present.
    always_comb begin
        show_nxt = (state_nxt == SHOW);
        code_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];
        supp_nxt = blank_lz & lz_mask[idx_nxt];
        bad_nxt  = ~bcd_valid(code_nxt);
    end

    // Registered display outputs and status pulses.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            digit_sel  <= '0;
            digit_code <= 4'd0;
            blank_q    <= 1'b1;
            frame_done <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            digit_sel  <= (show_nxt && !supp_nxt) ? (NUM_DIGITS'(1) << idx_nxt) : '0;
            digit_code <= show_nxt ? code_nxt : 4'd0;
            blank_q    <= !show_nxt || supp_nxt || bad_nxt;
            frame_done <= wrap;
            code_err   <= show_nxt && (tmr_nxt == TMR_LOAD) && bad_nxt;
        end
    end

    seven_segment_display_decoder u_decoder (
        .binary_input   (digit_code),
        .segment_output (seg_raw)
    );

    assign seg_out = blank_q ? SEG_BLANK : seg_raw;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: a frame-time model plus
// hand-computed checkpoints over directed scenarios.
module tb_seven_segment_scan_controller;

    localparam int N     = 4;
    localparam int S     = 4;
    localparam int B     = 1;
    localparam int FRAME = N * S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  digit_sel;
    logic [6:0]  seg_out;
    logic [3:0]  digit_code;
    logic        frame_done;
    logic        code_err;

    int checks = 0;
    int errors = 0;

    // Model state: m_t counts cycles since scanning started.
    int          m_sync = 0;
    int          m_t = 0;
    bit          m_run = 1'b0;
    bit          m_wrap = 1'b0;
    bit          m_lz = 1'b0;
    logic [15:0] m_pend = 16'h0;
    logic [15:0] m_disp = 16'h0;

    seven_segment_scan_controller #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (S),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .blank_lz   (blank_lz),
        .digit_sel  (digit_sel),
        .seg_out    (seg_out),
        .digit_code (digit_code),
        .frame_done (frame_done),
        .code_err   (code_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model, updated on the same events as the DUT.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_sync = 0;
            m_run  = 1'b0;
            m_wrap = 1'b0;
            m_lz   = 1'b0;
            m_t    = 0;
            m_pend = 16'h0;
            m_disp = 16'h0;
        end else if (m_sync < 2) begin
            m_sync++;
            m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (!m_run) m_disp = m_pend;
            if (!enable) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
                if (m_t % FRAME == 0) begin
                    m_wrap = 1'b1;
                    m_disp = m_pend;
                end
            end
            m_lz = blank_lz;
            if (load) m_pend = digits_in;
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        int slot, ph, dig, e_sel, e_seg, e_err;
        bit show, supp;
        forever begin
            @(negedge clk);
            e_sel = 0; e_seg = 0; e_err = 0; show = 1'b0; dig = 0;
            if (m_run) begin
                slot = (m_t / S) % N;
                ph   = m_t % S;
                dig  = int'((m_disp >> (4 * slot)) & 16'hF);
                show = (ph < S - B);
                supp = m_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 16'h0);
                e_sel = (show && !supp) ? (1 << slot) : 0;
                e_seg = (show && !supp && dig <= 9) ? int'(seg_of(dig)) : 0;
                e_err = (show && ph == 0 && dig > 9) ? 1 : 0;
            end
            check("model_digit_sel", digit_sel, e_sel);
            check("model_seg_out", seg_out, e_seg);
            if (show) check("model_digit_code", digit_code, dig);
            check("model_frame_done", frame_done, int'(m_wrap));
            check("model_code_err", code_err, e_err);
        end
    end

    // Directed scenarios with literal checkpoints.
    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_digit_sel", digit_sel, 0);
        check("rst_seg_out", seg_out, 0);
        check("rst_digit_code", digit_code, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_code_err", code_err, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Basic scan of 1234
        load = 1'b1; digits_in = 16'h1234; tick();
        load = 1'b0; tick();
        enable = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            case (k)
                0: begin
                    check("basic_s0_sel", digit_sel, 4'b0001);
                    check("basic_s0_code", digit_code, 4);
                    check("basic_s0_seg", seg_out, 7'b1100110);
                end
                2: check("basic_s0_last_show", digit_sel, 4'b0001);
                3: begin
                    check("basic_gap_sel", digit_sel, 0);
                    check("basic_gap_seg", seg_out, 0);
                end
                4: begin
                    check("basic_s1_sel", digit_sel, 4'b0010);
                    check("basic_s1_code", digit_code, 3);
                end
                8: begin
                    check("basic_s2_sel", digit_sel, 4'b0100);
                    check("basic_s2_code", digit_code, 2);
                end
                12: begin
                    check("basic_s3_sel", digit_sel, 4'b1000);
                    check("basic_s3_code", digit_code, 1);
                end
                15: check("basic_no_early_fd", frame_done, 0);
                16: begin
                    check("basic_frame_done", frame_done, 1);
                    check("basic_wrap_sel", digit_sel, 4'b0001);
                end
                default: ;
            endcase
        end

        // Leading-zero suppression on 0070, then turned off, then enable drop in slot 2
        enable = 1'b0; tick();
        load = 1'b1; digits_in = 16'h0070; blank_lz = 1'b1; tick();
        load = 1'b0; tick();
        enable = 1'b1;
        for (int k = 0; k <= 41; k++) begin
            tick();
            case (k)
                0: begin
                    check("lz_s0_sel", digit_sel, 4'b0001);
                    check("lz_s0_seg", seg_out, 7'b0111111);
                end
                4: begin
                    check("lz_s1_code", digit_code, 7);
                    check("lz_s1_seg", seg_out, 7'b0000111);
                end
                8: begin
                    check("lz_s2_sel", digit_sel, 0);
                    check("lz_s2_seg", seg_out, 0);
                end
                12: begin
                    check("lz_s3_sel", digit_sel, 0);
                    check("lz_s3_seg", seg_out, 0);
                end
                15: blank_lz = 1'b0;
                24: check("nolz_s2_sel", digit_sel, 4'b0100);
                28: begin
                    check("nolz_s3_sel", digit_sel, 4'b1000);
                    check("nolz_s3_seg", seg_out, 7'b0111111);
                end
                41: begin
                    check("drop_pre_sel", digit_sel, 4'b0100);
                    enable = 1'b0;
                end
                default: ;
            endcase
        end
        tick();
        check("drop_sel", digit_sel, 0);
        check("drop_seg", seg_out, 0);
        check("drop_fd", frame_done, 0);
        tick(); tick();
        enable = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            case (k)
                0: begin
                    check("reen_s0_sel", digit_sel, 4'b0001);
                    check("reen_s0_seg", seg_out, 7'b0111111);
                end
                3: check("reen_gap_sel", digit_sel, 0);
                4: check("reen_s1_code", digit_code, 7);
                default: ;
            endcase
        end

        // Tear-free update, including a load on the wrap edge itself
        enable = 1'b0; tick();
        load = 1'b1; digits_in = 16'h1111; tick();
        load = 1'b0; tick();
        enable = 1'b1;
        for (int k = 0; k <= 48; k++) begin
            tick();
            case (k)
                5: begin load = 1'b1; digits_in = 16'h2222; end
                6: load = 1'b0;
                12: check("tear_s3_old", digit_code, 1);
                14: check("tear_s3_old_late", digit_code, 1);
                16: begin
                    check("tear_new_code", digit_code, 2);
                    check("tear_new_fd", frame_done, 1);
                end
                31: begin load = 1'b1; digits_in = 16'h3333; end
                32: begin
                    load = 1'b0;
                    check("wrapload_held", digit_code, 2);
                end
                44: check("wrapload_still_old", digit_code, 2);
                48: check("wrapload_applied", digit_code, 3);
                default: ;
            endcase
        end

        // Invalid code A in slot 1
        enable = 1'b0; tick();
        load = 1'b1; digits_in = 16'h00A5; tick();
        load = 1'b0; tick();
        enable = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            tick();
            case (k)
                0: begin
                    check("bad_s0_code", digit_code, 5);
                    check("bad_s0_seg", seg_out, 7'b1101101);
                    check("bad_s0_err", code_err, 0);
                end
                4: begin
                    check("bad_s1_sel", digit_sel, 4'b0010);
                    check("bad_s1_seg", seg_out, 0);
                    check("bad_s1_err", code_err, 1);
                end
                5: check("bad_s1_err_once", code_err, 0);
                20: check("bad_s1_err_frame2", code_err, 1);
                33: check("pre_rst_code", digit_code, 5);
                default: ;
            endcase
        end

        // Asynchronous reset between edges while showing a digit
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", digit_sel, 0);
        check("arst_seg", seg_out, 0);
        check("arst_code", digit_code, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("arst_sync1_sel", digit_sel, 0);
        tick();
        check("arst_sync2_sel", digit_sel, 0);
        for (int k = 0; k <= 8; k++) begin
            tick();
            case (k)
                0: begin
                    check("post_rst_sel", digit_sel, 4'b0001);
                    check("post_rst_code", digit_code, 0);
                    check("post_rst_seg", seg_out, 7'b0111111);
                end
                4: check("post_rst_s1_code", digit_code, 0);
                8: check("post_rst_s2_code", digit_code, 0);
                default: ;
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
